// File: rtl/cache_writeback_ctrl.sv
// Miss handler for a 2-way cache: writes back a dirty LRU victim, fills the line, then signals completion.
// Optional build macro CACHE_WB_PERF_CNT_EN adds saturating writeback/fill counters.
module cache_writeback_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_req,
  input  logic [31:0]  mem_address,
  input  logic         lru,
  input  logic         dirty_0,
  input  logic         dirty_1,
  input  logic [23:0]  victim_tag,
  input  logic [255:0] victim_data,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata,
  output logic [255:0] fill_data,
  output logic         line_load,
  output logic         clr_dirty,
  output logic         miss_done,
  output logic         busy,
  output logic [1:0]   state_dbg
`ifdef CACHE_WB_PERF_CNT_EN
  ,
  output logic [15:0]  wb_count,
  output logic [15:0]  fill_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [23:0]    tag_q;
  logic [255:0]   wdata_q;
  logic           lru_q;
  logic [26:0]    line_addr_q;
  logic [255:0]   fill_q;
  logic           victim_dirty;
  logic           accept;
  logic           unused_inputs;

  assign victim_dirty  = lru ? dirty_1 : dirty_0;
  assign accept        = (state_q == IDLE) && miss_req;
  // Offset bits never reach memory; lru_q is kept only to pin the victim way for the transaction.
  assign unused_inputs = ^{mem_address[4:0], lru_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Snapshot of the victim and miss address; inputs may change freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      wdata_q     <= '0;
      lru_q       <= 1'b0;
      line_addr_q <= '0;
    end else if (accept) begin
      tag_q       <= victim_tag;
      wdata_q     <= victim_data;
      lru_q       <= lru;
      line_addr_q <= mem_address[31:5];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fill_q <= '0;
    else if (line_load) fill_q <= pmem_rdata;
  end

  // Memory handshake: pmem_read/pmem_write with address and write data are held
  // constant until the cycle pmem_resp=1; that cycle completes the access.
  always_comb begin
    state_d      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    clr_dirty    = 1'b0;
    line_load    = 1'b0;
    miss_done    = 1'b0;
    fill_data    = fill_q;
    case (state_q)
      IDLE: begin
        if (miss_req) state_d = victim_dirty ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q, line_addr_q[2:0], 5'b0};
        pmem_wdata   = wdata_q;
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {line_addr_q, 5'b0};
        if (pmem_resp) begin
          line_load = 1'b1;
          fill_data = pmem_rdata;
          state_d   = DONE;
        end
      end
      DONE: begin
        miss_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

`ifdef CACHE_WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count   <= '0;
      fill_count <= '0;
    end else begin
      if (clr_dirty && (wb_count != 16'hFFFF))   wb_count   <= wb_count + 16'd1;
      if (line_load && (fill_count != 16'hFFFF)) fill_count <= fill_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// Scoreboard bench for cache_writeback_ctrl: random and directed misses against a transaction-level model.
module tb_cache_writeback_ctrl;

  localparam int W = 290;
  localparam logic [1:0] K_WB   = 2'd1;
  localparam logic [1:0] K_FILL = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req;
  logic [31:0]  mem_address;
  logic         lru, dirty_0, dirty_1;
  logic [23:0]  victim_tag;
  logic [255:0] victim_data;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic [255:0] fill_data;
  logic         line_load, clr_dirty, miss_done, busy;
  logic [1:0]   state_dbg;
`ifdef CACHE_WB_PERF_CNT_EN
  logic [15:0]  wb_count, fill_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wb = 1;
  int n_fill = 1;
  int rsp_cnt = 0;
  int exp_wb = 0;
  int exp_fill = 0;
  bit resp_manual = 1'b0;
  logic [255:0] fill_line;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_it;
  logic [1:0]   mon_kind;
  logic [255:0] last_fill;
  bit           prev_done = 1'b0;

  cache_writeback_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .mem_address(mem_address),
    .lru(lru), .dirty_0(dirty_0), .dirty_1(dirty_1),
    .victim_tag(victim_tag), .victim_data(victim_data),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .fill_data(fill_data), .line_load(line_load), .clr_dirty(clr_dirty),
    .miss_done(miss_done), .busy(busy), .state_dbg(state_dbg)
`ifdef CACHE_WB_PERF_CNT_EN
    , .wb_count(wb_count), .fill_count(fill_count)
`endif
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Memory responder: answers after n_wb / n_fill cycles of a held request.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_manual) pmem_resp = 1'b0;
      pmem_rdata = rand_line();
      if (!rst_n || resp_manual) begin
        rsp_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        rsp_cnt++;
        if (rsp_cnt >= (pmem_write ? n_wb : n_fill)) begin
          pmem_resp = 1'b1;
          if (pmem_read) pmem_rdata = fill_line;
          rsp_cnt = 0;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Monitor: compares every presented output against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("rw_exclusive", {255'd0, pmem_read & pmem_write}, 256'd0);
        chk("busy", {255'd0, busy}, {255'd0, pmem_read | pmem_write | miss_done});
        chk("clr_dirty", {255'd0, clr_dirty}, {255'd0, pmem_write & pmem_resp});
        chk("line_load", {255'd0, line_load}, {255'd0, pmem_read & pmem_resp});
        if (prev_done) chk("idle_after_done", {255'd0, busy}, 256'd0);
        prev_done = miss_done;
        if (pmem_write || pmem_read || miss_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=rd%0d_wr%0d_done%0d required=none",
                     pmem_read, pmem_write, miss_done);
          end else begin
            mon_it   = exp_q[0];
            mon_kind = pmem_write ? K_WB : (pmem_read ? K_FILL : K_DONE);
            chk("event_kind", {254'd0, mon_kind}, {254'd0, mon_it[289:288]});
            if (mon_kind != mon_it[289:288]) begin
              if (pmem_resp || miss_done) void'(exp_q.pop_front());
            end else if (mon_kind == K_WB) begin
              chk("wb_addr", {224'd0, pmem_address}, {224'd0, mon_it[287:256]});
              chk("wb_data", pmem_wdata, mon_it[255:0]);
              if (pmem_resp) void'(exp_q.pop_front());
            end else if (mon_kind == K_FILL) begin
              chk("fill_addr", {224'd0, pmem_address}, {224'd0, mon_it[287:256]});
              if (pmem_resp) begin
                chk("fill_data", fill_data, mon_it[255:0]);
                last_fill = mon_it[255:0];
                void'(exp_q.pop_front());
              end
            end else begin
              chk("done_cycle", 256'(cyc), {224'd0, mon_it[287:256]});
              chk("fill_hold", fill_data, last_fill);
              void'(exp_q.pop_front());
            end
          end
        end
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic do_miss(input logic l, input logic d0, input logic d1, input logic [23:0] tag,
                         input logic [255:0] vd, input logic [31:0] a,
                         input int nwb, input int nf, input bit hold);
    logic dirty;
    int   lat;
    int   g;
    wait_idle();
    lru = l; dirty_0 = d0; dirty_1 = d1;
    victim_tag = tag; victim_data = vd; mem_address = a;
    n_wb = nwb; n_fill = nf; fill_line = rand_line();
    miss_req = 1'b1;
    dirty = l ? d1 : d0;
    if (dirty) exp_q.push_back({K_WB, tag, a[7:5], 5'b0, vd});
    exp_q.push_back({K_FILL, a[31:5], 5'b0, fill_line});
    lat = 2 + nf + (dirty ? nwb : 0);
    exp_q.push_back({K_DONE, 32'(cyc + lat - 1), 256'd0});
    exp_wb   += dirty ? 1 : 0;
    exp_fill += 1;
    @(negedge clk);
    if (!hold) miss_req = 1'b0;
    g = 0;
    // Scramble every input while the transaction is in flight.
    while (busy && g < 300) begin
      victim_tag  = 24'($urandom);
      victim_data = rand_line();
      mem_address = $urandom;
      lru         = 1'($urandom_range(0, 1));
      dirty_0     = 1'($urandom_range(0, 1));
      dirty_1     = 1'($urandom_range(0, 1));
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    logic        rl, r0, r1;
    logic [31:0] ra;
    rst_n = 1'b0; miss_req = 1'b0; mem_address = '0; lru = 1'b0;
    dirty_0 = 1'b0; dirty_1 = 1'b0; victim_tag = '0; victim_data = '0; fill_line = '0;
    last_fill = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pmem_address", {224'd0, pmem_address}, 256'd0);
    chk("rst_pmem_read", {255'd0, pmem_read}, 256'd0);
    chk("rst_pmem_write", {255'd0, pmem_write}, 256'd0);
    chk("rst_pmem_wdata", pmem_wdata, 256'd0);
    chk("rst_fill_data", fill_data, 256'd0);
    chk("rst_pulses", {253'd0, line_load, clr_dirty, miss_done}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_state", {254'd0, state_dbg}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean miss at 0x1234 with a 3-cycle fill.
    do_miss(1'b0, 1'b0, 1'b1, 24'h123456, rand_line(), 32'h0000_1234, 1, 3, 1'b0);
    // Dirty miss, victim tag ABCDEF, set 1.
    ra = $urandom;
    do_miss(1'b1, 1'b0, 1'b1, 24'hABCDEF, rand_line(), {ra[31:8], 3'b001, ra[4:0]}, 2, 2, 1'b0);

    // Spurious pmem_resp while idle.
    wait_idle();
    resp_manual = 1'b1;
    pmem_resp   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("spurious_busy", {255'd0, busy}, 256'd0);
      chk("spurious_pulses", {253'd0, line_load, clr_dirty, miss_done}, 256'd0);
    end
    pmem_resp   = 1'b0;
    resp_manual = 1'b0;
    @(negedge clk);

    // miss_req held high across back-to-back transactions.
    do_miss(1'b1, 1'b1, 1'b1, 24'($urandom), rand_line(), $urandom, 1, 1, 1'b1);
    do_miss(1'b0, 1'b0, 1'b0, 24'($urandom), rand_line(), $urandom, 1, 2, 1'b1);
    do_miss(1'b0, 1'b1, 1'b0, 24'($urandom), rand_line(), $urandom, 3, 1, 1'b0);

    // Reset asserted mid-fill.
    wait_idle();
    lru = 1'b0; dirty_0 = 1'b0; mem_address = $urandom; n_fill = 1000; miss_req = 1'b1;
    exp_q.push_back({K_FILL, mem_address[31:5], 5'b0, 256'd0});
    @(negedge clk);
    miss_req = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_reset_read", {255'd0, pmem_read}, 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_read", {255'd0, pmem_read}, 256'd0);
    chk("async_rst_addr", {224'd0, pmem_address}, 256'd0);
    chk("async_rst_busy", {255'd0, busy}, 256'd0);
    chk("async_rst_state", {254'd0, state_dbg}, 256'd0);
    exp_q.delete();
    exp_wb = 0;
    exp_fill = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("post_reset_idle", {255'd0, busy}, 256'd0);
    end
    @(negedge clk);

    // Randomized misses.
    for (int i = 0; i < 30; i++) begin
      rl = 1'($urandom_range(0, 1));
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      do_miss(rl, r0, r1, 24'($urandom), rand_line(), $urandom,
              $urandom_range(1, 5), $urandom_range(1, 5),
              (i != 29) && ($urandom_range(0, 3) == 0));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 256'(exp_q.size()), 256'd0);
`ifdef CACHE_WB_PERF_CNT_EN
    chk("wb_count", {240'd0, wb_count}, 256'(exp_wb));
    chk("fill_count", {240'd0, fill_count}, 256'(exp_fill));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
